prbs_err_led_sched: RTL and testbench

Error-indication scheduler for the PRBS LED test path. Maintains one 2-bit saturating error count per PRBS lane, accepts lane or global clear requests through a request/acknowledge handshake, and time-shares a single LED display between the lanes with a round-robin dwell timer. Sits between the per-lane PRBS checkers, which produce error pulses, and the front-panel LED driver.

---
 rtl/prbs_err_led_sched_if.sv | 35 +++
 rtl/prbs_err_led_sched.sv | 155 +++++++++++++++
 tb/tb_prbs_err_led_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_err_led_sched_if.sv
// prbs_err_led_sched_if
// Bundles the lane error inputs, clear handshake, scan hold and LED display
// outputs of prbs_err_led_sched.
//   err_pulse : per-lane error strobe (checker -> scheduler)
//   clr_req   : clear request level, held until clr_ack
//   clr_lane  : lane to clear; any value >= NLANE clears all lanes
//   hold      : freezes the display scan
//   led_lane  : one-hot select of the displayed lane
//   led_level : count of the displayed lane
//   sat_flag  : per-lane saturation flag
//   clr_ack   : one-cycle clear acknowledge
// modport master drives the requests; modport slave is the scheduler.
interface prbs_err_led_sched_if #(
  parameter int NLANE = 4,
  parameter int LW    = 3
);
  logic [NLANE-1:0] err_pulse;
  logic             clr_req;
  logic [LW-1:0]    clr_lane;
  logic             hold;
  logic [NLANE-1:0] led_lane;
  logic [1:0]       led_level;
  logic [NLANE-1:0] sat_flag;
  logic             clr_ack;

  modport master (
    output err_pulse, clr_req, clr_lane, hold,
    input  led_lane, led_level, sat_flag, clr_ack
  );

  modport slave (
    input  err_pulse, clr_req, clr_lane, hold,
    output led_lane, led_level, sat_flag, clr_ack
  );
endinterface

// File: rtl/prbs_err_led_sched.sv
// prbs_err_led_sched
// Keeps a 2-bit saturating error count per PRBS lane, clears one lane or all
// lanes through a request/acknowledge handshake, and time-shares one LED
// display between the lanes with a round-robin dwell timer.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : prbs_err_led_sched_if.slave (err_pulse, clr_req, clr_lane, hold in;
//          led_lane, led_level, sat_flag, clr_ack out)
// Build option: define PRBS_SKIP_ZERO_EN to make the scan skip lanes whose
// count is zero and blank led_lane while the selected lane's count is zero.
module prbs_err_led_sched #(
  parameter int NLANE     = 4,
  parameter int DWELL_CYC = 40_000_000,
  parameter int LW        = 3
) (
  input logic                clk,
  input logic                rst,
  prbs_err_led_sched_if.slave bus
);

  localparam int          PW = $clog2(NLANE);
  localparam int          TW = $clog2(DWELL_CYC);
  localparam int unsigned NL = NLANE;

  typedef enum logic {IDLE, ACK} clr_state_t;

  clr_state_t       state, state_next;
  logic             clr_fire;
  logic             ack_next;
  logic [NLANE-1:0] lane_hit;
  logic [NLANE-1:0] err_prev;
  logic [NLANE-1:0] err_rise;
  logic [1:0]       cnt [NLANE];
  logic [PW-1:0]    ptr, ptr_adv;
  logic [TW-1:0]    timer;
  logic             dwell_end;
  logic [NLANE-1:0] lane_sel;
  logic [NLANE-1:0] sat_next;

  // Clear handshake FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Clear handshake FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.clr_req) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clear handshake FSM: outputs (requests seen in ACK are ignored)
  always_comb begin
    clr_fire = (state == IDLE) && bus.clr_req;
    ack_next = (state == ACK);
  end

  always_comb begin
    lane_hit = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      lane_hit[i] = clr_fire &&
                    ((bus.clr_lane >= LW'(NLANE)) || (bus.clr_lane == LW'(i)));
    end
  end

  assign err_rise = bus.err_pulse & ~err_prev;

  // A clear on a lane takes priority over a rising edge in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_prev <= '0;
      for (int unsigned i = 0; i < NL; i++) cnt[i] <= '0;
    end else begin
      err_prev <= bus.err_pulse;
      for (int unsigned i = 0; i < NL; i++) begin
        if (lane_hit[i])                      cnt[i] <= '0;
        else if (err_rise[i] && cnt[i] != 2'd3) cnt[i] <= cnt[i] + 2'd1;
      end
    end
  end

  assign dwell_end = (timer == TW'(DWELL_CYC - 1));

`ifdef PRBS_SKIP_ZERO_EN
  // Search forward from the lane after the current one for a nonzero count;
  // with none found the pointer stays put.
  always_comb begin
    logic          found;
    logic [PW-1:0] cand;
    ptr_adv = ptr;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i < NL; i++) begin
      cand = PW'((32'(ptr) + i) % NL);
      if (!found && cnt[cand] != 2'd0) begin
        ptr_adv = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    lane_sel = NLANE'(1) << ptr;
    if (cnt[ptr] == 2'd0) lane_sel = '0;
  end
`else
  always_comb begin
    ptr_adv = (ptr == PW'(NLANE - 1)) ? '0 : ptr + 1'b1;
  end

  always_comb begin
    lane_sel = NLANE'(1) << ptr;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      ptr   <= '0;
    end else if (!bus.hold) begin
      if (dwell_end) begin
        timer <= '0;
        ptr   <= ptr_adv;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  always_comb begin
    sat_next = '0;
    for (int unsigned i = 0; i < NL; i++) sat_next[i] = (cnt[i] == 2'd3);
  end

  // Outputs are registered from the previous cycle's state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.led_lane  <= '0;
      bus.led_level <= '0;
      bus.sat_flag  <= '0;
      bus.clr_ack   <= 1'b0;
    end else begin
      bus.led_lane  <= lane_sel;
      bus.led_level <= cnt[ptr];
      bus.sat_flag  <= sat_next;
      bus.clr_ack   <= ack_next;
    end
  end

endmodule

// File: tb/tb_prbs_err_led_sched.sv
module tb_prbs_err_led_sched;
  localparam int NL = 4;
  localparam int DW = 4;
`ifdef PRBS_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  prbs_err_led_sched_if #(.NLANE(NL), .LW(3)) bus ();

  prbs_err_led_sched #(.NLANE(NL), .DWELL_CYC(DW), .LW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cnt [NL];
  logic [3:0] m_prev;
  int         m_ptr;
  int         m_elapsed;
  bit         m_inack;
  logic [3:0] e_lane, e_sat;
  logic [1:0] e_level;
  bit         e_ack;

  function automatic int next_lane();
    if (!SKIP) return (m_ptr + 1) % NL;
    for (int k = 1; k < NL; k++)
      if (m_cnt[(m_ptr + k) % NL] != 0) return (m_ptr + k) % NL;
    return m_ptr;
  endfunction

  task automatic model_step();
    bit fire;
    if (rst) begin
      for (int i = 0; i < NL; i++) m_cnt[i] = 0;
      m_prev = '0; m_ptr = 0; m_elapsed = 0; m_inack = 0;
      e_lane = '0; e_level = '0; e_sat = '0; e_ack = 0;
    end else begin
      e_lane  = 4'(1 << m_ptr);
      if (SKIP && m_cnt[m_ptr] == 0) e_lane = '0;
      e_level = 2'(m_cnt[m_ptr]);
      for (int i = 0; i < NL; i++) e_sat[i] = (m_cnt[i] == 3);
      e_ack = m_inack;
      if (!bus.hold) begin
        m_elapsed++;
        if (m_elapsed == DW) begin
          m_elapsed = 0;
          m_ptr = next_lane();
        end
      end
      fire    = !m_inack && bus.clr_req;
      m_inack = fire;
      for (int i = 0; i < NL; i++) begin
        if (fire && (int'(bus.clr_lane) >= NL || int'(bus.clr_lane) == i)) m_cnt[i] = 0;
        else if (bus.err_pulse[i] && !m_prev[i] && m_cnt[i] < 3) m_cnt[i]++;
      end
      m_prev = bus.err_pulse;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input logic [3:0] e, input bit q,
                       input logic [2:0] l, input bit h);
    rst = r; bus.err_pulse = e; bus.clr_req = q; bus.clr_lane = l; bus.hold = h;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         r;
    logic [3:0] err;
    bit         hold;
    logic [3:0] e_lane;
    logic [1:0] e_level;
    logic [3:0] e_sat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input bit r, input logic [3:0] err,
                              input bit hold, input logic [3:0] el,
                              input logic [1:0] lv, input logic [3:0] sat);
    vec_t v;
    v.r = r; v.err = err; v.hold = hold; v.e_lane = el; v.e_level = lv; v.e_sat = sat;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  initial begin
    drive(1'b1, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_prev = '0; m_ptr = 0; m_elapsed = 0; m_inack = 0;
    @(negedge clk);

`ifndef PRBS_SKIP_ZERO_EN
    // Saturation on lane 2, level-high pulse on lanes 1/2, scan and hold.
    add(1, 1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    add(1, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000);
    add(1, 0, 4'b0100, 0, 4'b0001, 0, 4'b0000);
    add(1, 0, 4'b0000, 0, 4'b0001, 0, 4'b0000);
    add(1, 0, 4'b0100, 0, 4'b0001, 0, 4'b0000);
    add(1, 0, 4'b0000, 0, 4'b0010, 0, 4'b0000);
    add(1, 0, 4'b0100, 0, 4'b0010, 0, 4'b0000);
    add(1, 0, 4'b0000, 0, 4'b0010, 0, 4'b0100);
    add(1, 0, 4'b0100, 0, 4'b0010, 0, 4'b0100);
    add(1, 0, 4'b0000, 0, 4'b0100, 3, 4'b0100);
    add(3, 0, 4'b0110, 0, 4'b0100, 3, 4'b0100);
    add(4, 0, 4'b0110, 0, 4'b1000, 0, 4'b0100);
    add(3, 0, 4'b0110, 0, 4'b0001, 0, 4'b0100);
    add(1, 0, 4'b0000, 0, 4'b0001, 0, 4'b0100);
    add(1, 0, 4'b0000, 0, 4'b0010, 1, 4'b0100);
    add(6, 0, 4'b0000, 1, 4'b0010, 1, 4'b0100);
    add(3, 0, 4'b0000, 0, 4'b0010, 1, 4'b0100);
    add(1, 0, 4'b0000, 0, 4'b0100, 3, 4'b0100);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].err, 1'b0, '0, tbl[i].hold);
      tick();
      check($sformatf("vec%0d_lane", i),  bus.led_lane,  tbl[i].e_lane);
      check($sformatf("vec%0d_level", i), bus.led_level, tbl[i].e_level);
      check($sformatf("vec%0d_sat", i),   bus.sat_flag,  tbl[i].e_sat);
      check($sformatf("vec%0d_ack", i),   bus.clr_ack,   1'b0);
    end
`endif

    // Lane clear: counts {3,2,1,3}, clear lane 3, request ignored in ACK.
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b1111, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b1011, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b1001, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick();
    check("setup_sat", bus.sat_flag, 4'b1001);
    drive(0, 4'b0000, 1, 3'd3, 0); tick();
    check("lclr_ack0", bus.clr_ack, 1'b0);
    drive(0, 4'b0000, 1, 3'd0, 0); tick();
    check("lclr_ack1", bus.clr_ack, 1'b1);
    check("lclr_sat", bus.sat_flag, 4'b0001);
    drive(0, 4'b0000, 0, 3'd0, 0); tick();
    check("lclr_ack2", bus.clr_ack, 1'b0);
    check("lclr_ignored", bus.sat_flag, 4'b0001);

    // Global clear colliding with a lane 0 rising edge.
    drive(0, 4'b0001, 1, 3'd7, 0); tick();
    check("gclr_ack0", bus.clr_ack, 1'b0);
    drive(0, 4'b0000, 0, 3'd0, 0); tick();
    check("gclr_ack1", bus.clr_ack, 1'b1);
    check("gclr_sat", bus.sat_flag, 4'b0000);
    tick();
    check("gclr_ack2", bus.clr_ack, 1'b0);
    // Lane 0 restarts from zero: two edges must not saturate it.
    drive(0, 4'b0001, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b0001, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0); tick(); tick();
    check("gclr_cnt0", bus.sat_flag, 4'b0000);

    // Reset landing in the ACK cycle.
    drive(0, 4'b0000, 1, 3'd1, 0); tick();
    drive(1, 4'b0000, 0, 3'd0, 0); tick();
    check("rst_ack", bus.clr_ack, 1'b0);
    check("rst_lane", bus.led_lane, 4'b0000);
    check("rst_level", bus.led_level, 2'd0);
    check("rst_sat", bus.sat_flag, 4'b0000);
    drive(0, 4'b0000, 0, 3'd0, 0); tick();
    check("rel_lane", bus.led_lane, SKIP ? 4'b0000 : 4'b0001);
    check("rel_ack", bus.clr_ack, 1'b0);

`ifdef PRBS_SKIP_ZERO_EN
    drive(1, 4'b0000, 0, 0, 0); tick();
    drive(0, 4'b0100, 0, 0, 0); tick();
    drive(0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("skip_lane%0d", i), bus.led_lane, 4'b0100);
      check($sformatf("skip_level%0d", i), bus.led_level, 2'd1);
    end
    drive(0, 4'b0000, 1, 3'd7, 0); tick();
    drive(0, 4'b0000, 0, 3'd0, 0); tick(); tick();
    check("skip_blank", bus.led_lane, 4'b0000);
`endif

    // Randomized run against the reference model.
    drive(1, 4'b0000, 0, 0, 0); tick();
    for (int n = 0; n < 400; n++) begin
      logic [3:0] flip;
      for (int b = 0; b < NL; b++) flip[b] = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 99) == 0, bus.err_pulse ^ flip,
            $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 7) == 0);
      tick();
      check($sformatf("rnd%0d_lane", n),  bus.led_lane,  e_lane);
      check($sformatf("rnd%0d_level", n), bus.led_level, e_level);
      check($sformatf("rnd%0d_sat", n),   bus.sat_flag,  e_sat);
      check($sformatf("rnd%0d_ack", n),   bus.clr_ack,   e_ack);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
